// File: rtl/sd_mem_copy_pkg.sv
// rtl/sd_mem_copy_pkg.sv - shared types and default parameters for the memory copy master
// Holds the controller state enum and the default geometry constants used by
// sd_mem_copy_master and its read-latency pipe.
package sd_mem_copy_pkg;

   localparam int unsigned SD_ADDR_W_DEF       = 10;
   localparam int unsigned SD_DATA_W_DEF       = 32;
   localparam int unsigned SD_READ_LATENCY_DEF = 1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RD    = 3'd1,
      ST_RWAIT = 3'd2,
      ST_WR    = 3'd3,
      ST_DONE  = 3'd4
   } sd_state_e;

endpackage

// File: rtl/sd_rd_latency_pipe.sv
// rtl/sd_rd_latency_pipe.sv - fixed-latency read valid pipe producing the capture strobe
// Ports:
//   clk, reset   - clock and synchronous active-high reset (clears in-flight reads)
//   issue_i      - high during the cycle a read is presented to the slave
//   capture_o    - high during the cycle whose closing edge must sample readdata
module sd_rd_latency_pipe #(
   parameter int DEPTH = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic issue_i,
   output logic capture_o
);

   logic [DEPTH-1:0] vld_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q <= '0;
      end else begin
         vld_q[0] <= issue_i;
         for (int i = 1; i < DEPTH; i++) begin
            vld_q[i] <= vld_q[i-1];
         end
      end
   end

   // Stage DEPTH-1 is high DEPTH cycles after the issue cycle, so the edge
   // that ends that cycle is exactly DEPTH edges after the read was sampled.
   assign capture_o = vld_q[DEPTH-1];

endmodule

// File: rtl/sd_mem_copy_master.sv
// rtl/sd_mem_copy_master.sv - Avalon-MM memory copy / fill master
// Copies word_count words from src_addr to dst_addr (ascending, wrapping) over a
// fixed-latency, no-waitrequest memory slave. Optional fill mode (macro
// SD_MEM_COPY_FILL_EN) writes fill_value instead of reading the source.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   start, src_addr, dst_addr,
//   word_count, fill_mode,
//   fill_value                 - command, sampled only while idle
//   busy, done                 - status; done is a one-cycle pulse
//   address, byteenable,
//   chipselect, write,
//   writedata, clken, readdata - Avalon-MM master port
module sd_mem_copy_master
   import sd_mem_copy_pkg::*;
#(
   parameter int ADDR_W       = SD_ADDR_W_DEF,
   parameter int DATA_W       = SD_DATA_W_DEF,
   parameter int READ_LATENCY = SD_READ_LATENCY_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     src_addr,
   input  logic [ADDR_W-1:0]     dst_addr,
   input  logic [ADDR_W:0]       word_count,
   input  logic                  fill_mode,
   input  logic [DATA_W-1:0]     fill_value,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_W-1:0]     address,
   output logic [DATA_W/8-1:0]   byteenable,
   output logic                  chipselect,
   output logic                  write,
   output logic [DATA_W-1:0]     writedata,
   output logic                  clken,
   input  logic [DATA_W-1:0]     readdata
);

   localparam logic [2:0] S_IDLE  = 3'(ST_IDLE);
   localparam logic [2:0] S_RD    = 3'(ST_RD);
   localparam logic [2:0] S_RWAIT = 3'(ST_RWAIT);
   localparam logic [2:0] S_WR    = 3'(ST_WR);
   localparam logic [2:0] S_DONE  = 3'(ST_DONE);

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] src_q, src_d;
   logic [ADDR_W-1:0] dst_q, dst_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic              fill_q, fill_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   logic              fill_cmd;
   logic [DATA_W-1:0] fill_val_in;
   logic              capture;

`ifdef SD_MEM_COPY_FILL_EN
   assign fill_cmd    = fill_mode;
   assign fill_val_in = fill_value;
`else
   logic unused_fill;
   assign unused_fill = ^{fill_mode, fill_value};
   assign fill_cmd    = 1'b0;
   assign fill_val_in = '0;
`endif

   sd_rd_latency_pipe #(
      .DEPTH (READ_LATENCY)
   ) u_rd_pipe (
      .clk       (clk),
      .reset     (reset),
      .issue_i   (state_q == S_RD),
      .capture_o (capture)
   );

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      cnt_d   = cnt_q;
      fill_d  = fill_q;
      wdata_d = wdata_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               src_d   = src_addr;
               dst_d   = dst_addr;
               cnt_d   = word_count;
               fill_d  = fill_cmd;
               // In fill mode the write register simply holds the pattern;
               // a copy overwrites it with each captured word.
               wdata_d = fill_val_in;
               if (word_count == '0) begin
                  state_d = S_DONE;
               end else if (fill_cmd) begin
                  state_d = S_WR;
               end else begin
                  state_d = S_RD;
               end
            end
         end
         S_RD: begin
            state_d = S_RWAIT;
         end
         S_RWAIT: begin
            if (capture) begin
               wdata_d = readdata;
               state_d = S_WR;
            end
         end
         S_WR: begin
            cnt_d = cnt_q - (ADDR_W+1)'(1);
            src_d = src_q + ADDR_W'(1);
            dst_d = dst_q + ADDR_W'(1);
            if (cnt_q == (ADDR_W+1)'(1)) begin
               state_d = S_DONE;
            end else if (fill_q) begin
               state_d = S_WR;
            end else begin
               state_d = S_RD;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         cnt_q   <= '0;
         fill_q  <= 1'b0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         cnt_q   <= cnt_d;
         fill_q  <= fill_d;
         wdata_q <= wdata_d;
      end
   end

   // Bus outputs decode straight from the state register, so a reset edge
   // that forces IDLE silences the bus on that same edge.
   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_DONE);
   assign chipselect = (state_q == S_RD) || (state_q == S_WR);
   assign write      = (state_q == S_WR);
   assign byteenable = chipselect ? '1 : '0;
   assign writedata  = (state_q == S_WR) ? wdata_q : '0;
   assign clken      = 1'b1;

   always_comb begin
      address = '0;
      if (state_q == S_RD) begin
         address = src_q;
      end else if (state_q == S_WR) begin
         address = dst_q;
      end
   end

endmodule

// File: tb/tb_sd_mem_copy_master.sv
// tb/tb_sd_mem_copy_master.sv - self-checking bench for sd_mem_copy_master
module tb_sd_mem_copy_master;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 32;
   localparam int RL     = 1;
   localparam int DEPTH  = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [ADDR_W-1:0] src_addr;
   logic [ADDR_W-1:0] dst_addr;
   logic [ADDR_W:0]   word_count;
   logic              fill_mode;
   logic [DATA_W-1:0] fill_value;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] address;
   logic [3:0]        byteenable;
   logic              chipselect;
   logic              write;
   logic [DATA_W-1:0] writedata;
   logic              clken;
   logic [DATA_W-1:0] readdata;

   sd_mem_copy_master #(
      .ADDR_W       (ADDR_W),
      .DATA_W       (DATA_W),
      .READ_LATENCY (RL)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .src_addr   (src_addr),
      .dst_addr   (dst_addr),
      .word_count (word_count),
      .fill_mode  (fill_mode),
      .fill_value (fill_value),
      .busy       (busy),
      .done       (done),
      .address    (address),
      .byteenable (byteenable),
      .chipselect (chipselect),
      .write      (write),
      .writedata  (writedata),
      .clken      (clken),
      .readdata   (readdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_val(input int a);
      if (a >= 'h010 && a <= 'h013) return 32'h0000_00A0 + 32'(a - 'h010);
      if (a >= 'h040 && a <= 'h042) return 32'h0000_5500 + 32'(a - 'h040);
      if (a >= 'h0A0 && a <= 'h0A2) return 32'h0000_6600 + 32'(a - 'h0A0);
      if (a >= 'h300 && a <= 'h307) return 32'h0000_7700 + 32'(a - 'h300);
      return (32'(a) * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   logic        pre;
   logic [31:0] mem [DEPTH];
   logic [31:0] rd_pipe [RL];

   always @(posedge clk) begin
      if (pre) begin
         for (int a = 0; a < DEPTH; a++) mem[a] <= init_val(a);
      end else if (chipselect && write) begin
         mem[address] <= writedata;
      end
      rd_pipe[0] <= (chipselect && !write) ? mem[address] : 32'h0BAD_F00D;
      for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
   end
   assign readdata = rd_pipe[RL-1];

   // Model: per-cycle expectations. kind 0 idle, 1 read, 2 read wait,
   // 3 copy write, 4 fill write, 5 done.
   typedef struct {
      int          kind;
      int          addr;
      int          src;
      logic [31:0] val;
   } exp_t;

   exp_t        q[$];
   logic [31:0] model_mem [DEPTH];
   int          rd_log[$];
   int          wr_cyc[$];
   int          done_cyc[$];
   int          ncyc;
   int          total = 0;
   int          bad   = 0;
   bit          chk_en = 1'b0;

   task automatic push_cmd(input int s, input int d, input int c, input bit f, input logic [31:0] v);
      exp_t e;
      bit   eff;
`ifdef SD_MEM_COPY_FILL_EN
      eff = f;
`else
      eff = 1'b0;
`endif
      e = '{kind: 0, addr: 0, src: 0, val: 32'h0};
      q.push_back(e);
      for (int i = 0; i < c; i++) begin
         if (eff) begin
            q.push_back('{kind: 4, addr: (d + i) % DEPTH, src: 0, val: v});
         end else begin
            q.push_back('{kind: 1, addr: (s + i) % DEPTH, src: 0, val: 32'h0});
            for (int w = 0; w < RL; w++) q.push_back('{kind: 2, addr: 0, src: 0, val: 32'h0});
            q.push_back('{kind: 3, addr: (d + i) % DEPTH, src: (s + i) % DEPTH, val: 32'h0});
         end
      end
      q.push_back('{kind: 5, addr: 0, src: 0, val: 32'h0});
   endtask

   initial begin
      exp_t        e;
      logic        eb, ed, ecs, ew, ca, cd, cb, ok;
      logic [9:0]  ea;
      logic [31:0] edat;
      logic [3:0]  ebe;
      for (int a = 0; a < DEPTH; a++) model_mem[a] = init_val(a);
      ncyc = 0;
      wait (chk_en);
      forever begin
         @(negedge clk);
         ncyc++;
         if (chipselect === 1'b1 && write === 1'b0) rd_log.push_back(int'(address));
         if (chipselect === 1'b1 && write === 1'b1) wr_cyc.push_back(ncyc);
         if (done === 1'b1) done_cyc.push_back(ncyc);
         if (q.size() > 0) e = q.pop_front();
         else e = '{kind: 0, addr: 0, src: 0, val: 32'h0};
         eb = 1'b1; ed = 1'b0; ecs = 1'b0; ew = 1'b0;
         ca = 1'b0; cd = 1'b0; cb = 1'b0; ea = '0; edat = '0; ebe = '0;
         case (e.kind)
            0: begin eb = 1'b0; ca = 1'b1; cd = 1'b1; cb = 1'b1; end
            1: begin ecs = 1'b1; ca = 1'b1; ea = 10'(e.addr); end
            3, 4: begin
               ecs = 1'b1; ew = 1'b1; ca = 1'b1; cd = 1'b1; cb = 1'b1;
               ea = 10'(e.addr); ebe = 4'hF;
               edat = (e.kind == 3) ? model_mem[e.src] : e.val;
            end
            5: ed = 1'b1;
            default: ;
         endcase
         ok = (busy === eb) && (done === ed) && (chipselect === ecs) && (write === ew) &&
              (clken === 1'b1) && (!ca || address === ea) && (!cd || writedata === edat) &&
              (!cb || byteenable === ebe);
         total++;
         if (!ok) begin
            bad++;
            $display("FAIL bus_cycle %0d kind=%0d: got busy=%b done=%b cs=%b wr=%b addr=%h be=%h wdata=%h clken=%b want busy=%b done=%b cs=%b wr=%b addr=%h be=%h wdata=%h",
                     ncyc, e.kind, busy, done, chipselect, write, address, byteenable, writedata, clken,
                     eb, ed, ecs, ew, ea, ebe, edat);
         end
         if (e.kind == 3 || e.kind == 4) model_mem[e.addr] = edat;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int s, input int d, input int c, input bit f, input logic [31:0] v);
      src_addr   = 10'(s);
      dst_addr   = 10'(d);
      word_count = 11'(c);
      fill_mode  = f;
      fill_value = v;
   endtask

   task automatic issue(input int s, input int d, input int c, input bit f, input logic [31:0] v);
      drive(s, d, c, f, v);
      start = 1'b1;
      push_cmd(s, d, c, f, v);
      step();
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (q.size() != 0 && n < 5000) begin
         step();
         n++;
      end
      if (q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL wait_idle: got %0d pending cycles want 0", q.size());
         q.delete();
      end
   endtask

   initial begin
      int n, r0, w0, s, d, c, sel, diffs;
      reset = 1'b1; pre = 1'b1; start = 1'b0;
      drive(0, 0, 0, 1'b0, 32'h0);
      repeat (3) step();
      reset = 1'b0; pre = 1'b0;
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_cs_wr", {30'd0, chipselect, write}, 32'd0);
      chk("reset_addr", 32'(address), 32'd0);
      chk("reset_wdata_be", writedata | 32'(byteenable), 32'd0);
      chk_en = 1'b1;
      step();

      // basic copy and completion latency
      issue('h010, 'h200, 4, 1'b0, 32'h0);
      n = 1;
      while (done !== 1'b1 && n < 200) begin step(); n++; end
      chk("copy4_done_cycle", 32'(n), 32'd13);
      wait_idle();
      for (int i = 0; i < 4; i++) chk("copy4_dst", mem['h200 + i], 32'h0000_00A0 + 32'(i));

      // zero count
      r0 = rd_log.size(); w0 = wr_cyc.size();
      issue('h055, 'h066, 0, 1'b0, 32'h0);
      chk("zero_done_next", 32'(done), 32'd1);
      wait_idle();
      chk("zero_no_cs", 32'((rd_log.size() - r0) + (wr_cyc.size() - w0)), 32'd0);

      // address wrap on source
      r0 = rd_log.size();
      issue('h3FE, 'h100, 4, 1'b0, 32'h0);
      wait_idle();
      chk("wrap_nreads", 32'(rd_log.size() - r0), 32'd4);
      chk("wrap_rd0", 32'(rd_log[r0]),     32'h3FE);
      chk("wrap_rd1", 32'(rd_log[r0 + 1]), 32'h3FF);
      chk("wrap_rd2", 32'(rd_log[r0 + 2]), 32'h000);
      chk("wrap_rd3", 32'(rd_log[r0 + 3]), 32'h001);

      // fill (or copy without the feature)
      w0 = wr_cyc.size(); r0 = done_cyc.size();
      issue('h040, 'h020, 3, 1'b1, 32'hDEAD_BEEF);
      wait_idle();
`ifdef SD_MEM_COPY_FILL_EN
      chk("fill_b2b_1", 32'(wr_cyc[w0 + 1] - wr_cyc[w0]), 32'd1);
      chk("fill_b2b_2", 32'(wr_cyc[w0 + 2] - wr_cyc[w0]), 32'd2);
      chk("fill_done", 32'(done_cyc[r0] - wr_cyc[w0 + 2]), 32'd1);
      for (int i = 0; i < 3; i++) chk("fill_dst", mem['h020 + i], 32'hDEAD_BEEF);
`else
      for (int i = 0; i < 3; i++) chk("nofill_copy_dst", mem['h020 + i], 32'h0000_5500 + 32'(i));
`endif

      // reset during the second write of an 8-word copy
      issue('h080, 'h300, 8, 1'b0, 32'h0);
      repeat (2 * (2 + RL) - 1) step();
      chk("abort_in_wr2", {write, 22'd0, address}, {1'b1, 22'd0, 10'h301});
      reset = 1'b1;
      step();
      reset = 1'b0;
      q.delete();
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_cs", 32'(chipselect), 32'd0);
      step();
      for (int i = 2; i < 8; i++) chk("abort_untouched", mem['h300 + i], 32'h0000_7700 + 32'(i));
      issue('h090, 'h310, 2, 1'b0, 32'h0);
      wait_idle();

      // start while busy is ignored
      issue('h0A0, 'h0B0, 3, 1'b0, 32'h0);
      drive('h1D0, 'h1C0, 5, 1'b1, 32'h1111_2222);
      start = 1'b1;
      step();
      start = 1'b0;
      wait_idle();
      for (int i = 0; i < 3; i++) chk("ignored_dst", mem['h0B0 + i], 32'h0000_6600 + 32'(i));
      chk("ignored_other", mem['h1C0], init_val('h1C0));

      // randomized commands, including overlapping ranges
      for (int t = 0; t < 24; t++) begin
         s = $urandom_range(0, DEPTH - 1);
         c = $urandom_range(0, 6);
         sel = $urandom_range(0, 3);
         if (sel == 0) d = (s + 1) % DEPTH;
         else if (sel == 1) d = (s + DEPTH - 1) % DEPTH;
         else d = $urandom_range(0, DEPTH - 1);
         issue(s, d, c, 1'($urandom_range(0, 1)), $urandom);
         wait_idle();
         repeat ($urandom_range(0, 2)) step();
      end
      step();

      diffs = 0;
      for (int a = 0; a < DEPTH; a++) if (mem[a] !== model_mem[a]) diffs++;
      chk("final_mem_diffs", 32'(diffs), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish want finish");
      $fatal(1);
   end

endmodule

// File: doc/sd_mem_copy_master.md
SD_MEM_COPY_MASTER -- requirements
Module: sd_mem_copy_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-address width of the target memory.
REQ-002 SHALL have parameter DATA_W, default 32, data width; byteenable width is DATA_W/8.
REQ-003 SHALL have parameter READ_LATENCY, default 1, fixed cycles from read-issue to readdata valid (range 1..4).
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, one-cycle command strobe.
REQ-007 SHALL have port src_addr, input, ADDR_W, first source word address.
REQ-008 SHALL have port dst_addr, input, ADDR_W, first destination word address.
REQ-009 SHALL have port word_count, input, ADDR_W+1, words to transfer (0..2^ADDR_W).
REQ-010 SHALL have port fill_mode, input, 1, write fill_value instead of copying (see REQ-030).
REQ-011 SHALL have port fill_value, input, DATA_W, fill pattern.
REQ-012 SHALL have port busy, output, 1, high while a command is in progress.
REQ-013 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-014 SHALL have ports address (ADDR_W), byteenable (DATA_W/8), chipselect (1), write (1), writedata (DATA_W), clken (1), all outputs, as Avalon-MM master to a fixed-latency, no-waitrequest memory slave.
REQ-015 SHALL have port readdata, input, DATA_W, slave read data.

Function
REQ-016 SHALL implement states IDLE, RD, RWAIT, WR, DONE.
REQ-017 IDLE: start=1 SHALL latch src_addr, dst_addr, word_count, fill_mode, fill_value; next state RD (copy), WR (fill), or DONE if word_count=0.
REQ-018 RD SHALL drive chipselect=1, write=0, address=current src for exactly one cycle; next RWAIT.
REQ-019 RWAIT SHALL last READ_LATENCY cycles; readdata SHALL be captured on the edge exactly READ_LATENCY cycles after the RD cycle; next WR.
REQ-020 WR SHALL drive chipselect=1, write=1, byteenable=all ones, address=current dst, writedata=captured word (or fill_value) for one cycle.
REQ-021 After each WR the remaining count SHALL decrement and src/dst SHALL increment by 1 modulo 2^ADDR_W (wrap 1023->0 at default).
REQ-022 WR with remaining count reaching 0 SHALL go to DONE; otherwise RD (copy) or WR (fill).
REQ-023 DONE SHALL last one cycle with done=1, busy=1; next IDLE.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 Copy throughput SHALL be 2+READ_LATENCY cycles/word; fill 1 cycle/word.
REQ-026 start while busy SHALL be ignored with no side effect.
REQ-027 Overlapping ranges SHALL be copied strictly ascending, no hazard protection.
REQ-028 clken SHALL be driven constant 1; chipselect/write SHALL be 0 in IDLE and DONE.

Reset
REQ-029 reset SHALL force IDLE and busy=0, done=0, chipselect=0, write=0, address=0, writedata=0, byteenable=0 on the same edge, aborting any command mid-transfer with no further bus cycles.

Configuration
REQ-030 Macro SD_MEM_COPY_FILL_EN defined: fill_mode/fill_value SHALL operate per REQ-017/020/025; undefined: fill_mode and fill_value SHALL be ignored and every command SHALL be a copy.

Structure
REQ-031 Package sd_mem_copy_pkg SHALL hold the state enum type and default ADDR_W/DATA_W/READ_LATENCY constants.
REQ-032 Sub-module sd_rd_latency_pipe (READ_LATENCY-deep valid shift register producing the capture strobe) SHALL be the one sub-module.

Verification
REQ-033 Copy src=0x010, dst=0x200, count=4, memory preloaded 0xA0..0xA3 -> dst 0x200..0x203 = 0xA0..0xA3; done exactly 12 cycles after start cycle +1 (READ_LATENCY=1).
REQ-034 count=0 -> no chipselect ever; done pulses on cycle after start.
REQ-035 Copy src=0x3FE, dst=0x100, count=4 -> reads 0x3FE,0x3FF,0x000,0x001 in order.
REQ-036 Fill (SD_MEM_COPY_FILL_EN) dst=0x020, count=3, value=0xDEADBEEF -> three back-to-back writes, done 1 cycle after last write; without macro same command performs copy.
REQ-037 reset asserted during 2nd WR of count=8 copy -> next cycle chipselect=0, busy=0; words 3..8 untouched; new start then operates normally.
REQ-038 start pulsed during busy with different addresses -> ignored; original transfer completes unchanged.
